niosii_system_nios2_qsys_0_nios2_oci_dct_packer: RTL and testbench

Producer side of the OCI debug compressed trace (DCT) interface. Packs the 2-bit instruction-trace atoms from the OCI trace source into 30-bit DCT frames of up to 15 atoms each. Presents each frame as `dct_buffer` and `dct_count`, together with the `test_ending` and `test_has_ended` run-status flags, to the OCI trace consumer and simulation test bench.

---
 rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if.sv | 22 ++
 rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv | 145 ++++++++++++++
 tb/tb_niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if.sv
// DCT frame handshake between the trace packer and its consumer.
// The master holds a frame stable until the slave takes it with dct_ready.
interface niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;

    modport master (
        output dct_buffer,
        output dct_count,
        output dct_valid,
        input  dct_ready
    );

    modport slave (
        input  dct_buffer,
        input  dct_count,
        input  dct_valid,
        output dct_ready
    );
endinterface

// File: rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into 15-atom DCT frames behind a
// one-deep holding register, with run/drain/ended sequencing.
module niosii_system_nios2_qsys_0_nios2_oci_dct_packer #(
    parameter int IDLE_FLUSH = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trace_start,
    input  logic       trace_stop,
    input  logic       atom_valid,
    input  logic [1:0] atom,
    input  logic       flush,
    input  logic       clr_overflow,
    niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if.master dct,
    output logic       test_ending,
    output logic       test_has_ended,
    output logic       overflow,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_ENDED
    } state_t;

    localparam bit          AUTO_EN   = (IDLE_FLUSH != 0);
    localparam logic [15:0] IDLE_MAX  = 16'(IDLE_FLUSH);
    localparam logic [15:0] IDLE_LAST =
        (IDLE_FLUSH == 0) ? 16'd0 : 16'(IDLE_FLUSH - 1);

    state_t      state_q, state_d;
    logic [29:0] pk_buf_q, pk_buf_d;
    logic [3:0]  pk_cnt_q, pk_cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic [15:0] idle_q, idle_d;
    logic [29:0] hold_buf_q;
    logic [3:0]  hold_cnt_q;
    logic        hold_vld_q;

    logic in_run, stop_run, hold_free, xfer;
    logic auto_hit, emit, acc, drop, drained;

    assign dct.dct_buffer = hold_buf_q;
    assign dct.dct_count  = hold_cnt_q;
    assign dct.dct_valid  = hold_vld_q;
    assign test_has_ended = (state_q == S_ENDED);

    always_comb begin
        in_run    = (state_q == S_RUN);
        stop_run  = in_run & trace_stop;
        hold_free = ~hold_vld_q | dct.dct_ready;
        xfer      = hold_vld_q & dct.dct_ready;
        // Atom presence alone blocks the idle timeout, keeping it off the acc path.
        auto_hit  = AUTO_EN && in_run && (pk_cnt_q != 4'd0)
                    && !atom_valid && (idle_q == IDLE_LAST);
        emit      = hold_free && ((pk_cnt_q == 4'd15)
                    || ((pk_cnt_q != 4'd0) && (flush_pend_q || auto_hit
                        || state_q == S_DRAIN)));
        acc       = in_run && atom_valid && ((pk_cnt_q != 4'd15) || emit);
        drop      = in_run && atom_valid && (pk_cnt_q == 4'd15) && !hold_free;
        drained   = (pk_cnt_q == 4'd0) && !flush_pend_q && !hold_vld_q;
    end

    always_comb begin
        pk_buf_d = emit ? 30'd0 : pk_buf_q;
        pk_cnt_d = emit ? 4'd0 : pk_cnt_q;
        if (acc) begin
            for (int i = 0; i < 15; i++) begin
                if (pk_cnt_d == 4'(i)) pk_buf_d[2*i +: 2] = atom;
            end
            pk_cnt_d = pk_cnt_d + 4'd1;
        end
        // A request only survives while there is something left to flush.
        flush_pend_d = ((flush_pend_q | auto_hit) & ~emit)
                       | flush | stop_run;
        if (pk_cnt_d == 4'd0) flush_pend_d = 1'b0;
    end

    always_comb begin
        idle_d = idle_q;
        if (acc || emit || !in_run) idle_d = 16'd0;
        else if (pk_cnt_q != 4'd0 && idle_q != IDLE_MAX)
            idle_d = idle_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (trace_start) state_d = S_RUN;
            S_RUN:   if (trace_stop) state_d = S_DRAIN;
            S_DRAIN: if (drained) state_d = S_ENDED;
            S_ENDED: if (trace_start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pk_buf_q     <= '0;
            pk_cnt_q     <= '0;
            flush_pend_q <= 1'b0;
            idle_q       <= '0;
            test_ending  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pk_buf_q     <= pk_buf_d;
            pk_cnt_q     <= pk_cnt_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
            test_ending  <= stop_run;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_buf_q <= '0;
            hold_cnt_q <= '0;
            hold_vld_q <= 1'b0;
        end else if (emit) begin
            hold_buf_q <= pk_buf_q;
            hold_cnt_q <= pk_cnt_q;
            hold_vld_q <= 1'b1;
        end else if (xfer) begin
            hold_vld_q <= 1'b0;
        end
    end

    // A drop in the clearing cycle counts as the first drop of the new tally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
            if (clr_overflow) drop_count <= drop ? 8'd1 : 8'd0;
            else if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer: frame vectors from a table plus
// hand-written backpressure, drain, auto-flush and reset sequences.
module tb_niosii_system_nios2_qsys_0_nios2_oci_dct_packer;

    logic       clk;
    logic       reset_n;
    logic       trace_start, trace_stop;
    logic       atom_valid;
    logic [1:0] atom;
    logic       flush, clr_overflow;
    logic       test_ending, test_has_ended, overflow;
    logic [7:0] drop_count;

    niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if dct_bus ();

    niosii_system_nios2_qsys_0_nios2_oci_dct_packer #(
        .IDLE_FLUSH(64)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trace_start    (trace_start),
        .trace_stop     (trace_stop),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush          (flush),
        .clr_overflow   (clr_overflow),
        .dct            (dct_bus.master),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    typedef struct {
        string       name;
        int          n;
        int          mode;
        logic [29:0] atoms;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vec[6];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] a);
        atom_valid = 1'b1;
        atom = a;
        step();
        atom_valid = 1'b0;
    endtask

    task automatic pulse_start();
        trace_start = 1'b1;
        step();
        trace_start = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [29:0] held;
        int k;
        int frames;
        checks = 0;
        errors = 0;
        // mode 0: full frame, 1: flush after last atom, 2: flush with last atom
        vec[0] = '{"full01", 15, 0, 30'h15555555, 30'h15555555, 4'd15};
        vec[1] = '{"part321", 3, 1, 30'h0000001B, 30'h0000001B, 4'd3};
        vec[2] = '{"single", 1, 1, 30'h00000002, 30'h00000002, 4'd1};
        vec[3] = '{"flush_last", 4, 2, 30'h000000D5, 30'h000000D5, 4'd4};
        vec[4] = '{"full_mix", 15, 0, 30'h24E4E4E4, 30'h24E4E4E4, 4'd15};
        vec[5] = '{"part8", 8, 1, 30'h0000E4E4, 30'h0000E4E4, 4'd8};

        reset_n = 1'b0;
        trace_start = 1'b0;
        trace_stop = 1'b0;
        atom_valid = 1'b0;
        atom = 2'd0;
        flush = 1'b0;
        clr_overflow = 1'b0;
        dct_bus.dct_ready = 1'b1;
        step();
        chk("rst_buf", 32'(dct_bus.dct_buffer), 32'h0);
        chk("rst_cnt", 32'(dct_bus.dct_count), 32'h0);
        chk("rst_valid", 32'(dct_bus.dct_valid), 32'h0);
        chk("rst_ending", 32'(test_ending), 32'h0);
        chk("rst_ended", 32'(test_has_ended), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_drops", 32'(drop_count), 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) send(2'd3);
        pulse_flush();
        step();
        chk("idle_ignores", 32'(dct_bus.dct_valid), 32'h0);

        pulse_start();
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vec[v].n; i++) begin
                atom_valid = 1'b1;
                atom = vec[v].atoms[2*i +: 2];
                flush = (vec[v].mode == 2) && (i == vec[v].n - 1);
                step();
            end
            atom_valid = 1'b0;
            flush = 1'b0;
            if (vec[v].mode == 1) pulse_flush();
            chk({vec[v].name, "_lat"}, 32'(dct_bus.dct_valid), 32'h0);
            step();
            chk({vec[v].name, "_valid"}, 32'(dct_bus.dct_valid), 32'h1);
            chk({vec[v].name, "_buf"}, 32'(dct_bus.dct_buffer),
                32'(vec[v].exp_buf));
            chk({vec[v].name, "_cnt"}, 32'(dct_bus.dct_count),
                32'(vec[v].exp_cnt));
            step();
            chk({vec[v].name, "_pulse"}, 32'(dct_bus.dct_valid), 32'h0);
        end

        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            chk("empty_flush", 32'(dct_bus.dct_valid), 32'h0);
            step();
        end

        send(2'd1); send(2'd2); send(2'd3); send(2'd0); send(2'd1);
        k = 0;
        while (!dct_bus.dct_valid && k < 100) begin
            step();
            k++;
        end
        chk("auto_delay", 32'(k), 32'd64);
        chk("auto_buf", 32'(dct_bus.dct_buffer), 32'h139);
        chk("auto_cnt", 32'(dct_bus.dct_count), 32'd5);
        step();

        frames = 0;
        for (int i = 0; i < 31; i++) begin
            atom_valid = (i < 30);
            atom = 2'd3;
            step();
            if (dct_bus.dct_valid) begin
                frames++;
                chk("tput_buf", 32'(dct_bus.dct_buffer), 32'h3FFFFFFF);
            end
        end
        atom_valid = 1'b0;
        chk("tput_frames", 32'(frames), 32'd2);
        chk("tput_ovf", 32'(overflow), 32'h0);
        step();

        dct_bus.dct_ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            send(2'(i % 4));
            if (i == 15) held = dct_bus.dct_buffer;
        end
        chk("bp_valid", 32'(dct_bus.dct_valid), 32'h1);
        chk("bp_hold", 32'(dct_bus.dct_buffer), 32'(held));
        chk("bp_buf", 32'(dct_bus.dct_buffer), 32'h24E4E4E4);
        chk("bp_cnt", 32'(dct_bus.dct_count), 32'd15);
        chk("bp_ovf", 32'(overflow), 32'h1);
        chk("bp_drops", 32'(drop_count), 32'd3);
        clr_overflow = 1'b1;
        send(2'd0);
        chk("clr_drop_ovf", 32'(overflow), 32'h1);
        chk("clr_drop_cnt", 32'(drop_count), 32'd1);
        step();
        clr_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'h0);
        chk("clr_cnt", 32'(drop_count), 32'd0);
        dct_bus.dct_ready = 1'b1;
        step();
        chk("b2b_valid", 32'(dct_bus.dct_valid), 32'h1);
        chk("b2b_buf", 32'(dct_bus.dct_buffer), 32'h13939393);
        chk("b2b_cnt", 32'(dct_bus.dct_count), 32'd15);
        step();
        chk("b2b_done", 32'(dct_bus.dct_valid), 32'h0);

        dct_bus.dct_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(2'd2);
        trace_stop = 1'b1;
        step();
        trace_stop = 1'b0;
        chk("stop_ending", 32'(test_ending), 32'h1);
        chk("stop_lat", 32'(dct_bus.dct_valid), 32'h0);
        send(2'd1);
        chk("stop_pulse", 32'(test_ending), 32'h0);
        chk("drain_valid", 32'(dct_bus.dct_valid), 32'h1);
        chk("drain_cnt", 32'(dct_bus.dct_count), 32'd7);
        chk("drain_buf", 32'(dct_bus.dct_buffer), 32'h2AAA);
        step();
        step();
        chk("drain_hold", 32'(dct_bus.dct_count), 32'd7);
        chk("drain_wait", 32'(test_has_ended), 32'h0);
        dct_bus.dct_ready = 1'b1;
        step();
        chk("drain_xfer", 32'(dct_bus.dct_valid), 32'h0);
        chk("drain_not_yet", 32'(test_has_ended), 32'h0);
        step();
        chk("drain_ended", 32'(test_has_ended), 32'h1);
        chk("ended_stays", 32'(dct_bus.dct_valid), 32'h0);
        pulse_start();
        chk("restart_clear", 32'(test_has_ended), 32'h0);

        trace_stop = 1'b1;
        step();
        trace_stop = 1'b0;
        chk("quick_ending", 32'(test_ending), 32'h1);
        chk("quick_not_yet", 32'(test_has_ended), 32'h0);
        step();
        chk("quick_pulse", 32'(test_ending), 32'h0);
        chk("quick_ended", 32'(test_has_ended), 32'h1);
        trace_start = 1'b1;
        trace_stop = 1'b1;
        step();
        trace_start = 1'b0;
        trace_stop = 1'b0;
        chk("both_start_wins", 32'(test_has_ended), 32'h0);
        chk("both_no_ending", 32'(test_ending), 32'h0);
        trace_stop = 1'b1;
        step();
        trace_stop = 1'b0;
        chk("both_in_run", 32'(test_ending), 32'h1);
        step();
        pulse_start();

        dct_bus.dct_ready = 1'b0;
        for (int i = 0; i < 24; i++) send(2'd1);
        chk("pre_rst_valid", 32'(dct_bus.dct_valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_buf", 32'(dct_bus.dct_buffer), 32'h0);
        chk("arst_cnt", 32'(dct_bus.dct_count), 32'h0);
        chk("arst_valid", 32'(dct_bus.dct_valid), 32'h0);
        chk("arst_ended", 32'(test_has_ended), 32'h0);
        chk("arst_ovf", 32'(overflow), 32'h0);
        step();
        reset_n = 1'b1;
        dct_bus.dct_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(2'd2);
        pulse_flush();
        step();
        chk("post_rst_idle", 32'(dct_bus.dct_valid), 32'h0);
        pulse_start();
        send(2'd3);
        send(2'd1);
        pulse_flush();
        step();
        chk("post_rst_valid", 32'(dct_bus.dct_valid), 32'h1);
        chk("post_rst_cnt", 32'(dct_bus.dct_count), 32'd2);
        chk("post_rst_buf", 32'(dct_bus.dct_buffer), 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
